// File: rtl/lock_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : lock_controller
//  Description : Keypad door-lock controller. Synchronises the keypad enter
//                and delete levels, detects their rising edges and runs a
//                LOCKED / UNLOCKED / LOCKOUT state machine with a changeable
//                4-digit BCD code, a failure counter and shared timer.
//  Revision    : 1.0  initial release
// ============================================================================
module lock_controller #(
  parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
  parameter int          MAX_FAIL       = 3,
  parameter int          LOCKOUT_CYCLES = 16,
  parameter int          UNLOCK_CYCLES  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] password,
  input  logic        enter,
  input  logic        delete,
  input  logic [2:0]  digit_count,
  output logic        unlocked,
  output logic        alarm,
  output logic        error,
  output logic        pw_changed,
  output logic [1:0]  fail_count
);

  // Timer is shared by the lockout and unlock phases, so it must hold the
  // larger of the two load values.
  localparam int c_timer_max = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
  localparam int c_timer_w   = (c_timer_max > 0) ? $clog2(c_timer_max + 1) : 1;

  localparam logic [c_timer_w-1:0] c_lockout_load = c_timer_w'(LOCKOUT_CYCLES);
  localparam logic [c_timer_w-1:0] c_unlock_load  = c_timer_w'(UNLOCK_CYCLES);
  localparam logic [c_timer_w-1:0] c_timer_one    = c_timer_w'(1);
  localparam logic [c_timer_w-1:0] c_timer_zero   = '0;
  localparam logic [2:0]           c_max_fail     = 3'(MAX_FAIL);

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKOUT  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronisation and edge detection
  // --------------------------------------------------------------------------
  logic       r_enter_s1;
  logic       r_enter_s2;
  logic       r_enter_s3;
  logic       r_delete_s1;
  logic       r_delete_s2;
  logic       r_delete_s3;
  logic [1:0] r_arm_cnt;
  logic       w_armed;
  logic       w_enter_ev;
  logic       w_delete_ev;

  // Two-flop synchronisers plus an edge flop; the arm counter suppresses the
  // false edge a level that was already high at reset release would create.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enter_s1  <= 1'b0;
      r_enter_s2  <= 1'b0;
      r_enter_s3  <= 1'b0;
      r_delete_s1 <= 1'b0;
      r_delete_s2 <= 1'b0;
      r_delete_s3 <= 1'b0;
      r_arm_cnt   <= 2'd0;
    end else begin
      r_enter_s1  <= enter;
      r_enter_s2  <= r_enter_s1;
      r_enter_s3  <= r_enter_s2;
      r_delete_s1 <= delete;
      r_delete_s2 <= r_delete_s1;
      r_delete_s3 <= r_delete_s2;
      if (r_arm_cnt != 2'd3) begin
        r_arm_cnt <= r_arm_cnt + 2'd1;
      end
    end
  end

  // Edge flop only carries real history once it has been loaded from a
  // synchronised sample, which is after the third post-reset edge.
  assign w_armed     = (r_arm_cnt == 2'd3);
  assign w_enter_ev  = w_armed & r_enter_s2  & ~r_enter_s3;
  assign w_delete_ev = w_armed & r_delete_s2 & ~r_delete_s3;

  // --------------------------------------------------------------------------
  // Entry qualification
  // --------------------------------------------------------------------------
  logic [15:0] r_code;
  logic        w_digits_ok;
  logic        w_entry_valid;
  logic        w_code_match;

  assign w_digits_ok   = (password[15:12] <= 4'd9) && (password[11:8] <= 4'd9) &&
                         (password[7:4]   <= 4'd9) && (password[3:0]  <= 4'd9);
  assign w_entry_valid = (digit_count >= 3'd4) && w_digits_ok;
  assign w_code_match  = (password == r_code);

  // --------------------------------------------------------------------------
  // Main state machine
  // --------------------------------------------------------------------------
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [15:0]            w_code_nxt;
  logic [c_timer_w-1:0]   r_timer;
  logic [c_timer_w-1:0]   w_timer_nxt;
  logic [1:0]             r_fail;
  logic [1:0]             w_fail_nxt;
  logic [2:0]             w_fail_inc;
  logic                   w_timer_done;
  logic                   w_error_nxt;
  logic                   w_pw_changed_nxt;
  logic                   r_error;
  logic                   r_pw_changed;
  logic                   r_unlocked;
  logic                   r_alarm;

  assign w_fail_inc   = {1'b0, r_fail} + 3'd1;
  // A timer value of 1 means this is the last cycle of the phase; testing
  // "<= 1" also keeps a zero load from ever wrapping.
  assign w_timer_done = (r_timer <= c_timer_one);

  // Next-state, code, timer, failure count and pulse outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_code_nxt       = r_code;
    w_timer_nxt      = r_timer;
    w_fail_nxt       = r_fail;
    w_error_nxt      = 1'b0;
    w_pw_changed_nxt = 1'b0;

    case (r_state)
      ST_LOCKED: begin
        // A simultaneous delete swallows the enter event.
        if (w_enter_ev && !w_delete_ev) begin
          if (w_entry_valid && w_code_match) begin
            w_state_nxt = ST_UNLOCKED;
            w_fail_nxt  = 2'd0;
            w_timer_nxt = c_unlock_load;
          end else begin
            w_error_nxt = 1'b1;
            if (w_fail_inc >= c_max_fail) begin
              w_state_nxt = ST_LOCKOUT;
              w_fail_nxt  = 2'd0;
              w_timer_nxt = c_lockout_load;
            end else begin
              w_fail_nxt = w_fail_inc[1:0];
            end
          end
        end
      end

      ST_UNLOCKED: begin
        if (w_delete_ev) begin
          w_state_nxt = ST_LOCKED;
          w_timer_nxt = c_timer_zero;
        end else if (w_enter_ev && w_entry_valid) begin
          w_code_nxt       = password;
          w_pw_changed_nxt = 1'b1;
          w_timer_nxt      = c_unlock_load;
        end else begin
          // An invalid entry is flagged but does not disturb the countdown.
          w_error_nxt = w_enter_ev;
          if (w_timer_done) begin
            w_state_nxt = ST_LOCKED;
            w_timer_nxt = c_timer_zero;
          end else begin
            w_timer_nxt = r_timer - c_timer_one;
          end
        end
      end

      ST_LOCKOUT: begin
        if (w_timer_done) begin
          w_state_nxt = ST_LOCKED;
          w_timer_nxt = c_timer_zero;
        end else begin
          w_timer_nxt = r_timer - c_timer_one;
        end
      end

      default: begin
        w_state_nxt = ST_LOCKED;
        w_timer_nxt = c_timer_zero;
        w_fail_nxt  = 2'd0;
      end
    endcase
  end

  // State, datapath and registered outputs; reset restores the factory code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_LOCKED;
      r_code       <= DEFAULT_CODE;
      r_timer      <= c_timer_zero;
      r_fail       <= 2'd0;
      r_error      <= 1'b0;
      r_pw_changed <= 1'b0;
      r_unlocked   <= 1'b0;
      r_alarm      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_code       <= w_code_nxt;
      r_timer      <= w_timer_nxt;
      r_fail       <= w_fail_nxt;
      r_error      <= w_error_nxt;
      r_pw_changed <= w_pw_changed_nxt;
      r_unlocked   <= (w_state_nxt == ST_UNLOCKED);
      r_alarm      <= (w_state_nxt == ST_LOCKOUT);
    end
  end

  assign unlocked   = r_unlocked;
  assign alarm      = r_alarm;
  assign error      = r_error;
  assign pw_changed = r_pw_changed;
  assign fail_count = r_fail;

endmodule
`default_nettype wire
